// File: rtl/tc_reg_arbiter.sv
// tc_reg_arbiter: round-robin sequencer sharing a load/save register bank between requesters
module tc_reg_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_REGS   = 8,
  parameter int BIT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ-1:0]             req_write_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [NUM_REQ*BIT_WIDTH-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic [NUM_REQ-1:0]             resp_valid_o,
  output logic                           resp_err_o,
  output logic [BIT_WIDTH-1:0]           resp_data_o,
  output logic                           busy_o,
  output logic [NUM_REGS-1:0]            reg_load_o,
  output logic [NUM_REGS-1:0]            reg_save_o,
  output logic [BIT_WIDTH-1:0]           reg_in_o,
  input  logic [NUM_REGS*BIT_WIDTH-1:0]  reg_out_i
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT} state_t;
  state_t                state_q;
  logic [IW-1:0]         last_q, id_q, win;
  logic                  found, write_q, oor_q, new_oor, new_wr;
  logic [ADDR_WIDTH-1:0] new_addr;
  logic [BIT_WIDTH-1:0]  new_wdata, or_out;
  // round-robin search starting one past the last winner
  always_comb begin
    found = 1'b0;
    win   = last_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req_valid_i[(int'(last_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        win   = IW'((int'(last_q) + k) % NUM_REQ);
      end
    end
  end
  // only loaded registers drive non-zero, so OR-ing the bank selects the read word
  always_comb begin
    or_out = '0;
    for (int i = 0; i < NUM_REGS; i++) or_out = or_out | reg_out_i[i*BIT_WIDTH +: BIT_WIDTH];
  end
  assign new_addr    = req_addr_i[win*ADDR_WIDTH +: ADDR_WIDTH];
  assign new_wdata   = req_wdata_i[win*BIT_WIDTH +: BIT_WIDTH];
  assign new_wr      = req_write_i[win];
  assign new_oor     = int'(new_addr) >= NUM_REGS;
  assign req_ready_o = (state_q == IDLE && found) ? NUM_REQ'(1) << win : '0;
  assign busy_o      = state_q != IDLE;
  // FSM: strobes are set on the grant edge so they appear exactly in ISSUE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_q       <= IW'(NUM_REQ - 1);
      id_q         <= '0;
      write_q      <= 1'b0;
      oor_q        <= 1'b0;
      reg_load_o   <= '0;
      reg_save_o   <= '0;
      reg_in_o     <= '0;
      resp_valid_o <= '0;
      resp_err_o   <= 1'b0;
      resp_data_o  <= '0;
    end else begin
      reg_load_o   <= '0;
      reg_save_o   <= '0;
      resp_valid_o <= '0;
      case (state_q)
        IDLE: if (found) begin
          state_q    <= ISSUE;
          last_q     <= win;
          id_q       <= win;
          write_q    <= new_wr;
          oor_q      <= new_oor;
          reg_save_o <= (new_wr && !new_oor) ? NUM_REGS'(1) << new_addr : '0;
          reg_load_o <= (!new_wr && !new_oor) ? NUM_REGS'(1) << new_addr : '0;
          if (new_wr && !new_oor) reg_in_o <= new_wdata;
        end
        ISSUE: begin
          state_q <= write_q ? IDLE : RWAIT;
          if (write_q) begin
            resp_valid_o <= NUM_REQ'(1) << id_q;
            resp_err_o   <= oor_q;
          end
        end
        RWAIT: begin
          state_q      <= IDLE;
          resp_valid_o <= NUM_REQ'(1) << id_q;
          resp_err_o   <= oor_q;
          resp_data_o  <= oor_q ? '0 : or_out;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
